// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline stage: a DEPTH-entry in-order buffer with the valid/allow
// handshake of a single stage register. It adds ready_go stall, flush,
// exception payload scrubbing, a sideband message channel and occupancy.
module pipe_stage_fifo #(
    parameter int               DATA_W        = 64,
    parameter int               MSG_W         = 16,
    parameter int               DEPTH         = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE    = '0,
    parameter bit               HOLD_ON_EMPTY = 1'b0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         valid_in,
    input  logic [DATA_W-1:0]            data_in,
    input  logic [MSG_W-1:0]             msg_in,
    input  logic                         exc_in,
    output logic                         allow_out,
    output logic                         valid_out,
    output logic [DATA_W-1:0]            data_out,
    output logic [MSG_W-1:0]             msg_out,
    output logic                         exc_out,
    input  logic                         allow_in,
    input  logic                         ready_go,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic [DATA_W-1:0] data_slot_reg [DEPTH];
    logic [MSG_W-1:0]  msg_slot_reg  [DEPTH];
    logic              exc_slot_reg  [DEPTH];

    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic [DEPTH-1:0]  slot_we;
    logic [DATA_W-1:0] data_wr;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign valid_out = !empty && ready_go;
    assign pop       = valid_out && allow_in;
    // Only a full buffer routes allow_in through to allow_out.
    assign allow_out = !full || pop;
    assign push      = valid_in && allow_out && !flush && aresetn;

    // Exception entries carry a harmless payload so later stages never act on it.
    assign data_wr   = exc_in ? NOP_VALUE : data_in;

    // One-hot write enable per slot, decoded from the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Slot storage: cleared only by reset; flush leaves stale contents in place.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!aresetn) begin
                data_slot_reg[i] <= NOP_VALUE;
                msg_slot_reg[i]  <= '0;
                exc_slot_reg[i]  <= 1'b0;
            end else if (slot_we[i]) begin
                data_slot_reg[i] <= data_wr;
                msg_slot_reg[i]  <= msg_in;
                exc_slot_reg[i]  <= exc_in;
            end
        end
    end

    // Pointers and occupancy; pointers wrap by natural overflow (DEPTH is 2^n).
    always_ff @(posedge aclk) begin
        if (!aresetn || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head presentation: visible even while stalled; empty shows NOP or stale head.
    always_comb begin
        data_out = data_slot_reg[rd_ptr_reg];
        msg_out  = msg_slot_reg[rd_ptr_reg];
        exc_out  = exc_slot_reg[rd_ptr_reg];
        if (empty) begin
            msg_out = '0;
            exc_out = 1'b0;
            if (!HOLD_ON_EMPTY) begin
                data_out = NOP_VALUE;
            end
        end
    end

    assign count = count_reg;

endmodule
